// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified memory between instruction fetch (IF) and
// the load/store path (LS). Each access runs through an IDLE -> BUSY -> RESP
// request/acknowledge sequence. LS has fixed priority over IF. Store byte
// enables and data are aligned to the byte address. Misaligned stores are
// rejected without touching memory. Accesses that wait TIMEOUT cycles without
// mem_ack are aborted with an error.
//
// Parameters:
//   TIMEOUT : cycles mem_req may stay high without mem_ack (1..65535)
//   CNT_W   : wait counter width, 2**CNT_W > TIMEOUT
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   if_req/if_addr                  fetch request, held until if_valid
//   if_rdata/if_valid/if_err        fetch response (one-cycle valid pulse)
//   ls_req/ls_we/ls_addr/ls_wdata   load/store request, held until ls_valid
//   ls_rdata/ls_valid/ls_err        load/store response (one-cycle valid pulse)
//   mem_req/mem_addr/mem_we/mem_wdata  memory request side
//   mem_rdata/mem_ack               memory response side
//   busy                            high whenever the FSM is not IDLE
// All outputs are registered.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_err,
    input  logic        ls_req,
    input  logic [3:0]  ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_valid,
    output logic        ls_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic              grant_ls_reg, grant_ls_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              mem_req_reg, mem_req_next;
    logic [31:0]       mem_addr_reg, mem_addr_next;
    logic [3:0]        mem_we_reg, mem_we_next;
    logic [31:0]       mem_wdata_reg, mem_wdata_next;
    logic [31:0]       if_rdata_reg, if_rdata_next;
    logic              if_valid_reg, if_valid_next;
    logic              if_err_reg, if_err_next;
    logic [31:0]       ls_rdata_reg, ls_rdata_next;
    logic              ls_valid_reg, ls_valid_next;
    logic              ls_err_reg, ls_err_next;
    logic              busy_reg, busy_next;

    // Fetches are word aligned by contract; the low address bits carry no meaning.
    logic              unused_if_addr_bits;
    assign unused_if_addr_bits = ^if_addr[1:0];

    logic [1:0]        offset;
    logic [3:0]        ls_we_aligned;
    logic [31:0]       ls_wdata_aligned;
    logic              ls_misaligned;

    assign offset           = ls_addr[1:0];
    assign ls_we_aligned    = ls_we << offset;
    assign ls_wdata_aligned = ls_wdata << {offset, 3'b000};
    // Words must sit on a word boundary and halves on an even byte.
    assign ls_misaligned    = ((ls_we == 4'b1111) && (offset != 2'b00)) ||
                              ((ls_we == 4'b0011) && offset[0]);

    always_comb begin
        state_next     = state_reg;
        grant_ls_next  = grant_ls_reg;
        cnt_next       = cnt_reg;
        mem_req_next   = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_we_next    = mem_we_reg;
        mem_wdata_next = mem_wdata_reg;
        if_rdata_next  = if_rdata_reg;
        ls_rdata_next  = ls_rdata_reg;
        if_valid_next  = 1'b0;
        if_err_next    = 1'b0;
        ls_valid_next  = 1'b0;
        ls_err_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (ls_req) begin
                    grant_ls_next  = 1'b1;
                    mem_addr_next  = {ls_addr[31:2], 2'b00};
                    mem_we_next    = ls_we_aligned;
                    mem_wdata_next = ls_wdata_aligned;
                    cnt_next       = '0;
                    if (ls_misaligned) begin
                        // Reject straight away; memory is never requested.
                        state_next    = RESP;
                        ls_valid_next = 1'b1;
                        ls_err_next   = 1'b1;
                    end else begin
                        state_next   = BUSY;
                        mem_req_next = 1'b1;
                    end
                end else if (if_req) begin
                    grant_ls_next  = 1'b0;
                    mem_addr_next  = {if_addr[31:2], 2'b00};
                    mem_we_next    = 4'b0000;
                    mem_wdata_next = 32'h0;
                    cnt_next       = '0;
                    state_next     = BUSY;
                    mem_req_next   = 1'b1;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_next = RESP;
                    if (grant_ls_reg) begin
                        ls_valid_next = 1'b1;
                        if (mem_we_reg == 4'b0000) begin
                            ls_rdata_next = mem_rdata;
                        end
                    end else begin
                        if_valid_next = 1'b1;
                        if_rdata_next = mem_rdata;
                    end
                end else if (cnt_reg == LAST_WAIT) begin
                    // Abort: mem_req drops and the granted side sees an error.
                    state_next = RESP;
                    if (grant_ls_reg) begin
                        ls_valid_next = 1'b1;
                        ls_err_next   = 1'b1;
                    end else begin
                        if_valid_next = 1'b1;
                        if_err_next   = 1'b1;
                    end
                end else begin
                    cnt_next     = cnt_reg + CNT_W'(1);
                    mem_req_next = 1'b1;
                end
            end
            RESP: begin
                // Requests are not looked at here, so a req still held high
                // during the response cycle cannot be granted twice.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            grant_ls_reg  <= 1'b0;
            cnt_reg       <= '0;
            mem_req_reg   <= 1'b0;
            mem_addr_reg  <= 32'h0;
            mem_we_reg    <= 4'b0000;
            mem_wdata_reg <= 32'h0;
            if_rdata_reg  <= 32'h0;
            if_valid_reg  <= 1'b0;
            if_err_reg    <= 1'b0;
            ls_rdata_reg  <= 32'h0;
            ls_valid_reg  <= 1'b0;
            ls_err_reg    <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_ls_reg  <= grant_ls_next;
            cnt_reg       <= cnt_next;
            mem_req_reg   <= mem_req_next;
            mem_addr_reg  <= mem_addr_next;
            mem_we_reg    <= mem_we_next;
            mem_wdata_reg <= mem_wdata_next;
            if_rdata_reg  <= if_rdata_next;
            if_valid_reg  <= if_valid_next;
            if_err_reg    <= if_err_next;
            ls_rdata_reg  <= ls_rdata_next;
            ls_valid_reg  <= ls_valid_next;
            ls_err_reg    <= ls_err_next;
            busy_reg      <= busy_next;
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_we    = mem_we_reg;
    assign mem_wdata = mem_wdata_reg;
    assign if_rdata  = if_rdata_reg;
    assign if_valid  = if_valid_reg;
    assign if_err    = if_err_reg;
    assign ls_rdata  = ls_rdata_reg;
    assign ls_valid  = ls_valid_reg;
    assign ls_err    = ls_err_reg;
    assign busy      = busy_reg;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch (IF) and the load/store path.
- The load/store path is driven by decoder outputs: memReg for loads, dwe for stores.
- Sequences every access through a request/acknowledge FSM, aligns store byte enables and write data to the address, rejects misaligned stores, and aborts accesses that exceed a timeout.
- Sits between the CPU core and the memory model.

Parameters:
- TIMEOUT, 255: maximum cycles mem_req may stay high without mem_ack before the access is aborted. Legal range 1..65535.
- CNT_W, 16: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held high with stable if_addr until if_valid
- if_addr  in  32  fetch byte address; word-aligned, bits [1:0] ignored
- if_rdata  out  32  fetched word
- if_valid  out  1  one-cycle response pulse for fetch
- if_err  out  1  valid with if_valid; fetch timed out
- ls_req  in  1  load/store request; held high with stable inputs until ls_valid
- ls_we  in  4  decoder dwe: 0000 = load, 0001 = byte, 0011 = half, 1111 = word
- ls_addr  in  32  load/store byte address
- ls_wdata  in  32  store data, LSB-justified
- ls_rdata  out  32  raw loaded word (extension is done downstream)
- ls_valid  out  1  one-cycle response pulse for load/store
- ls_err  out  1  valid with ls_valid; misaligned store or timeout
- mem_req  out  1  memory access strobe
- mem_addr  out  32  word address; ls_addr/if_addr with bits [1:0] forced to 0
- mem_we  out  4  aligned byte write enables; 0000 = read
- mem_wdata  out  32  aligned write data
- mem_rdata  in  32  read data; valid in the cycle mem_ack = 1
- mem_ack  in  1  access complete; sampled only while mem_req = 1
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, immediate): state = IDLE. All outputs are 0, including mem_req (dropped even mid-access), both valid pulses, both err flags, rdata registers and the counter.
- All outputs are registered.
- States and transitions:
  - IDLE:
    - If ls_req = 1: grant LS. Load/store has fixed priority over IF, since it belongs to the older instruction. If ls_req = 0 and if_req = 1: grant IF.
    - On grant, latch address, aligned we and aligned wdata; clear counter.
    - If the LS grant is misaligned, go to RESP without touching memory. Otherwise go to BUSY with mem_req = 1 from the next cycle.
  - BUSY:
    - mem_req = 1; mem_addr, mem_we and mem_wdata hold their latched values.
    - mem_ack = 1: capture mem_rdata into the granted side's rdata (rdata is written for reads only), then go to RESP.
    - No ack: counter increments. When counter == TIMEOUT-1 with no ack, drop mem_req, set err and go to RESP.
  - RESP: exactly one cycle. Granted side's valid = 1 (err as set); mem_req = 0. Go to IDLE. Requests are ignored in RESP, so a req still high in this cycle is not re-granted.
- Latency: grant in cycle t, mem_req high in t+1. With mem_ack in t+1 (zero wait), valid is in t+2 and IDLE in t+3. N wait cycles add N.
- Alignment, with o = ls_addr[1:0]:
  - mem_we = ls_we << o.
  - mem_wdata = ls_wdata << (8*o).
  - Misaligned: ls_we == 1111 with o != 0, or ls_we == 0011 with o[0] = 1. The response is ls_valid = 1, ls_err = 1, no mem_req, and memory is unmodified.
  - Loads (ls_we == 0000) are never misaligned here; the full word is returned raw.
- ls_rdata and if_rdata hold their value until the next successful read on that side.
- A requester dropping req while BUSY has no effect; the access completes and valid still pulses.
- mem_ack while not BUSY is ignored.

Test Plan:
- Fetch, zero wait: if_req = 1, if_addr = 0x0000_0104, mem_rdata = 0x0051_0093 with mem_ack in the first BUSY cycle → mem_addr = 0x104, mem_we = 0000, if_valid pulse 2 cycles after grant, if_rdata = 0x0051_0093, if_err = 0.
- Simultaneous requests: if_req and ls_req high together → LS served first; IF is granted in the IDLE cycle following LS RESP; each valid pulses exactly once.
- Byte store: ls_we = 0001, ls_addr = 0x0000_2003, ls_wdata = 0x0000_00AB → mem_addr = 0x2000, mem_we = 1000, mem_wdata = 0xAB00_0000.
- Half store: ls_we = 0011, ls_addr = 0x2002 → mem_we = 1100. Misaligned cases: ls_we = 1111 at 0x2002, and ls_we = 0011 at 0x2001 → mem_req never asserts; ls_valid = 1 and ls_err = 1 one cycle after grant.
- Timeout: TIMEOUT = 4, mem_ack held 0 → mem_req high exactly 4 cycles, then ls_valid = 1, ls_err = 1; a later mem_ack is ignored.
- Reset mid-access: rst_n pulled low while BUSY with 3 wait cycles elapsed → mem_req, busy and valid are 0 without waiting for a clock edge. After release, a new request is granted normally.
